// File: rtl/grid_pkg.sv
// grid_pkg: cell-type constants and controller state shared by the grid memory files.
package grid_pkg;
    localparam logic [1:0] CELL_WORLD = 2'b00;
    localparam logic [1:0] CELL_FOOD  = 2'b01;
    localparam logic [1:0] CELL_SNAKE = 2'b10;
    typedef enum logic {CLEAR, IDLE} state_t;
endpackage

// File: rtl/grid_ram.sv
// grid_ram: one write port, synchronous read-before-write display/lookahead ports;
// the old-value port exists only when GRID_MEMORY_OCC_CNT_EN is defined.
module grid_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
`ifdef GRID_MEMORY_OCC_CNT_EN
    input  logic [AW-1:0] ra_c,
    output logic [DW-1:0] rd_c,
`endif
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_a <= mem[ra_a];
        rd_b <= mem[ra_b];
`ifdef GRID_MEMORY_OCC_CNT_EN
        rd_c <= mem[ra_c];
`endif
    end
endmodule

// File: rtl/grid_memory.sv
// grid_memory: game grid store with sequential clear, guarded write port and two read ports.
// Define GRID_MEMORY_OCC_CNT_EN to build the occupancy counter.
module grid_memory
    import grid_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int CELL_W = 2,
    localparam int G  = GRID_W * GRID_H,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int AW = $clog2(G),
    localparam int OW = $clog2(G + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              wr_en,
    input  logic [XW-1:0]     wr_x,
    input  logic [YW-1:0]     wr_y,
    input  logic [CELL_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic [XW-1:0]     rd_x,
    input  logic [YW-1:0]     rd_y,
    output logic [CELL_W-1:0] rd_data,
    input  logic [XW-1:0]     lk_x,
    input  logic [YW-1:0]     lk_y,
    output logic [CELL_W-1:0] lk_data,
    output logic [OW-1:0]     occ_count
);
    state_t state, state_nx;
    logic [AW-1:0] clr_addr, clr_addr_nx, wr_a, rd_a, lk_a;
    logic [CELL_W-1:0] rd_ram, lk_ram;
    logic busy, acc, wr_ok, rd_ok, lk_ok, rd_v, lk_v;

    function automatic logic in_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return ({1'b0, x} < (XW+1)'(GRID_W)) && ({1'b0, y} < (YW+1)'(GRID_H));
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(int'(y) * GRID_W + int'(x));
    endfunction

    assign busy     = (state == CLEAR);
    assign clr_busy = busy;
    assign wr_ok    = in_grid(wr_x, wr_y);
    assign rd_ok    = in_grid(rd_x, rd_y);
    assign lk_ok    = in_grid(lk_x, lk_y);
    assign acc      = wr_en && !busy && wr_ok;
    // Out-of-range coordinates could alias another cell or overrun the array, so park them at 0.
    assign wr_a     = wr_ok ? addr_of(wr_x, wr_y) : '0;
    assign rd_a     = rd_ok ? addr_of(rd_x, rd_y) : '0;
    assign lk_a     = lk_ok ? addr_of(lk_x, lk_y) : '0;
    assign rd_data  = rd_v ? rd_ram : '0;
    assign lk_data  = lk_v ? lk_ram : '0;

    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        if (clr_req) begin
            state_nx    = CLEAR;
            clr_addr_nx = '0;
        end else if (busy) begin
            state_nx    = (clr_addr == AW'(G - 1)) ? IDLE : CLEAR;
            clr_addr_nx = (clr_addr == AW'(G - 1)) ? '0 : clr_addr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            rd_v     <= 1'b0;
            lk_v     <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
            rd_v     <= !busy && rd_ok;
            lk_v     <= !busy && lk_ok;
            wr_drop  <= wr_en && (busy || !wr_ok);
        end
    end

`ifdef GRID_MEMORY_OCC_CNT_EN
    logic [CELL_W-1:0] old_q;
    logic [OW-1:0] occ;
    logic p_v, p_nz;

    grid_ram #(.DEPTH(G), .AW(AW), .DW(CELL_W)) u_ram (
        .clk(clk), .we(busy || acc), .wa(busy ? clr_addr : wr_a), .wd(busy ? '0 : wr_data),
        .ra_a(rd_a), .ra_b(lk_a), .ra_c(wr_a), .rd_c(old_q), .rd_a(rd_ram), .rd_b(lk_ram)
    );

    // The old value is read on the write edge, so the count settles one cycle after the write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_v  <= 1'b0;
            p_nz <= 1'b0;
            occ  <= '0;
        end else begin
            p_v  <= acc;
            p_nz <= |wr_data;
            occ  <= busy ? '0 : occ + OW'(p_v && !(|old_q) && p_nz) - OW'(p_v && (|old_q) && !p_nz);
        end
    end

    assign occ_count = occ;
`else
    grid_ram #(.DEPTH(G), .AW(AW), .DW(CELL_W)) u_ram (
        .clk(clk), .we(busy || acc), .wa(busy ? clr_addr : wr_a), .wd(busy ? '0 : wr_data),
        .ra_a(rd_a), .ra_b(lk_a), .rd_a(rd_ram), .rd_b(lk_ram)
    );

    assign occ_count = '0;
`endif
endmodule

// File: tb/tb_grid_memory.sv
// tb_grid_memory: directed checks on a 5x3 grid (out-of-range coordinates reachable) plus a 4x4 clear-length check.
module tb_grid_memory;
`ifdef GRID_MEMORY_OCC_CNT_EN
    localparam bit OCC = 1'b1;
`else
    localparam bit OCC = 1'b0;
`endif
    localparam int G = 15;

    logic clk = 1'b0, rst = 1'b0, clr_req = 1'b0, wr_en = 1'b0;
    logic clr_busy, wr_drop;
    logic [2:0] wr_x = '0, rd_x = '0, lk_x = '0;
    logic [1:0] wr_y = '0, rd_y = '0, lk_y = '0;
    logic [1:0] wr_data = '0, rd_data, lk_data;
    logic [3:0] occ_count;

    logic busy4, drop4;
    logic [1:0] rd4, lk4;
    logic [4:0] occ4;

    int tests = 0, fails = 0, n, n4;

    always #5 clk = ~clk;

    grid_memory #(.GRID_W(5), .GRID_H(3), .CELL_W(2)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_drop(wr_drop),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .lk_x(lk_x), .lk_y(lk_y), .lk_data(lk_data), .occ_count(occ_count)
    );

    grid_memory #(.GRID_W(4), .GRID_H(4), .CELL_W(2)) dut4 (
        .clk(clk), .rst(rst), .clr_req(1'b0), .clr_busy(busy4),
        .wr_en(1'b0), .wr_x(2'd0), .wr_y(2'd0), .wr_data(2'd0), .wr_drop(drop4),
        .rd_x(2'd0), .rd_y(2'd0), .rd_data(rd4),
        .lk_x(2'd0), .lk_y(2'd0), .lk_data(lk4), .occ_count(occ4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [2:0] x, input logic [1:0] y, input logic [1:0] d);
        wr_en = en; wr_x = x; wr_y = y; wr_data = d;
    endtask

    task automatic set_rd(input logic [2:0] x, input logic [1:0] y);
        rd_x = x; rd_y = y; lk_x = x; lk_y = y;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_busy", clr_busy, 1);
        check("rst_rd", rd_data, 0);
        check("rst_lk", lk_data, 0);
        check("rst_drop", wr_drop, 0);
        check("rst_occ", occ_count, 0);

        rst = 1'b1;
        n = 0; n4 = 0;
        for (int i = 0; i < 40; i++) begin
            if (clr_busy) n++;
            if (busy4) n4++;
            tick();
        end
        check("clear_len_5x3", n, G);
        check("clear_len_4x4", n4, 16);
        check("occ_after_clear", occ_count, 0);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++) begin
                set_rd(3'(x), 2'(y));
                tick();
                check("zero_rd", rd_data, 0);
                check("zero_lk", lk_data, 0);
            end

        set_wr(1, 3, 2, 2'b10);
        set_rd(3, 2);
        tick();
        check("rbw_old", rd_data, 0);
        wr_en = 0;
        tick();
        check("rd_3_2", rd_data, 2);
        check("lk_3_2", lk_data, 2);
        check("occ_one", occ_count, OCC ? 1 : 0);

        set_wr(1, 0, 1, 2'b01);
        set_rd(5, 0);
        tick();
        check("rd_oob_x", rd_data, 0);
        wr_en = 0;
        set_rd(0, 1);
        tick();
        check("lk_0_1", lk_data, 1);
        check("occ_two", occ_count, OCC ? 2 : 0);

        set_wr(1, 5, 0, 2'b10);
        tick();
        check("drop_x", wr_drop, 1);
        wr_en = 0;
        tick();
        check("drop_clear", wr_drop, 0);
        check("alias_kept", rd_data, 1);
        set_wr(1, 0, 3, 2'b10);
        tick();
        check("drop_y", wr_drop, 1);
        wr_en = 0;
        tick();
        check("occ_after_drop", occ_count, OCC ? 2 : 0);

        set_rd(3, 2);
        clr_req = 1;
        tick();
        clr_req = 0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (!clr_busy) break;
            n++;
            clr_req = (n == 5);
            set_wr(n == 2, 1, 1, 2'b10);
            tick();
            if (n == 2) check("drop_busy", wr_drop, 1);
            if (n == 3) check("rd_in_clear", rd_data, 0);
        end
        clr_req = 0; wr_en = 0;
        check("restart_len", n, 5 + G);
        set_rd(1, 1);
        tick();
        check("busy_write_lost", rd_data, 0);
        set_rd(3, 2);
        tick();
        check("cleared_3_2", rd_data, 0);
        check("occ_restart", occ_count, 0);

        set_wr(1, 1, 1, 2'b01);
        tick();
        wr_en = 0;
        tick();
        check("occ_ow_1", occ_count, OCC ? 1 : 0);
        set_wr(1, 1, 1, 2'b10);
        tick();
        wr_en = 0;
        tick();
        check("occ_ow_2", occ_count, OCC ? 1 : 0);
        set_wr(1, 1, 1, 2'b00);
        tick();
        wr_en = 0;
        tick();
        check("occ_ow_0", occ_count, 0);

        set_wr(1, 2, 2, 2'b10);
        tick();
        set_wr(1, 2, 2, 2'b00);
        tick();
        set_wr(1, 2, 2, 2'b01);
        tick();
        wr_en = 0;
        set_rd(2, 2);
        tick();
        tick();
        check("b2b_rd", rd_data, 1);
        check("b2b_occ", occ_count, OCC ? 1 : 0);

        #2 rst = 1'b0;
        #1;
        check("async_rd", rd_data, 0);
        check("async_lk", lk_data, 0);
        check("async_busy", clr_busy, 1);
        check("async_occ", occ_count, 0);
        check("async_drop", wr_drop, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
